// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core's single data-memory port between the
// instruction fetch unit (IFU) and the load/store unit (LSU). Only one
// transaction is in flight at a time. LSU normally wins, but an aging counter
// forces an IFU grant after STARVE_LIMIT consecutive LSU grants made while the
// IFU was waiting.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [7:0]          lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                arb_err
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP
    } state_t;

    typedef enum logic {
        OWNER_IFU,
        OWNER_LSU
    } owner_t;

    state_t           state_q;
    state_t           state_d;
    owner_t           owner_q;
    logic [CNT_W-1:0] starve_cnt;

    // Mask bits above the port width are never forwarded; folding them here
    // keeps the whole mask port visibly consumed.
    logic unused_wmask_bits;
    assign unused_wmask_bits = ^lsu_wmask;

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the grant decision, which is made combinationally in IDLE.
    always_comb begin
        state_d       = state_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rst) begin
                    if (lsu_req_valid && (starve_cnt < LIMIT)) begin
                        lsu_req_ready = 1'b1;
                        state_d       = ST_REQ;
                    end else if (ifu_req_valid) begin
                        ifu_req_ready = 1'b1;
                        state_d       = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the winner's request fields and update the IFU aging counter on each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= OWNER_IFU;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            starve_cnt <= '0;
        end else if (lsu_req_ready) begin
            owner_q   <= OWNER_LSU;
            mem_addr  <= lsu_addr;
            mem_wen   <= lsu_wen;
            mem_wdata <= lsu_wen ? lsu_wdata : '0;
            mem_wmask <= lsu_wen ? lsu_wmask[MASK_W-1:0] : '0;
            if (!ifu_req_valid) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else if (ifu_req_ready) begin
            owner_q    <= OWNER_IFU;
            mem_addr   <= ifu_addr;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            starve_cnt <= '0;
        end
    end

    // Route the memory response to its owner as a one-cycle pulse; a response outside WAIT_RSP is flagged sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            ifu_rdata     <= '0;
            lsu_rdata     <= '0;
            arb_err       <= 1'b0;
        end else begin
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            if (mem_rsp_valid) begin
                if (state_q == ST_WAIT_RSP) begin
                    if (owner_q == OWNER_LSU) begin
                        lsu_rsp_valid <= 1'b1;
                        lsu_rdata     <= mem_wen ? '0 : mem_rdata;
                    end else begin
                        ifu_rsp_valid <= 1'b1;
                        ifu_rdata     <= mem_rdata;
                    end
                end else begin
                    arb_err <= 1'b1;
                end
            end
        end
    end

endmodule
